// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants,
// data-width limits and the NBits clamp helper.
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 vote per sample point).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_TICK   = 4'd7;
  localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] NBITS_MIN  = 4'd5;
  localparam logic [3:0] NBITS_MAX  = 4'd8;

  // Bit-relative tick at which a sample decision is available. The voter
  // needs the tick after MID_TICK to see its third vote.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] DECISION_TICK = MID_TICK + 4'd1;
`else
  localparam logic [3:0] DECISION_TICK = MID_TICK;
`endif

  // Out-of-range widths saturate to the nearest legal frame size.
  function automatic logic [3:0] clamp_nbits(input logic [3:0] n);
    if (n < NBITS_MIN) return NBITS_MIN;
    if (n > NBITS_MAX) return NBITS_MAX;
    return n;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Rx input conditioning: SYNC_STAGES-flop synchroniser for the asynchronous
// line, plus the sample decision and its valid strobe.
// Optional build macro: UART_RX_MAJORITY_EN adds a 2-of-3 voter around
// MID_TICK; without it the synchronised line at MID_TICK is the sample.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tick,
  input  logic       Rx,
  input  logic       active,
  input  logic [3:0] bit_pos,
  output logic       rx_s,
  output logic       sample,
  output logic       sample_valid
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Metastability synchroniser for the asynchronous serial line.
  always_ff @(posedge Clk or posedge Rst) begin
    // NOTE: flops reset to 1 (idle line) so reset release never looks like a start edge.
    if (Rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], Rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic vote_a;
  logic vote_b;

  // Capture the two early votes; the third is the live line at decision time.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else if (Tick && active) begin
      if (bit_pos == MID_TICK - 4'd1) vote_a <= rx_s;
      if (bit_pos == MID_TICK)        vote_b <= rx_s;
    end
  end

  assign sample = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
`else
  assign sample = rx_s;
`endif

  assign sample_valid = Tick && active && (bit_pos == DECISION_TICK);

endmodule

// File: rtl/uart_rs232_rx.sv
// RS-232 UART receiver: 5..8 data bits, LSB first, one stop bit, timed by a
// shared 16x-oversample Tick enable. Each word is delivered with a one-Clk
// RxDone strobe; FrameErr flags a low stop bit in the same cycle.
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 vote per sample point,
// one Tick of extra latency).
module uart_rs232_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tick,
  input  logic       Rx,
  input  logic [3:0] NBits,
  output logic [7:0] RxData,
  output logic       RxDone,
  output logic       FrameErr,
  output logic       Busy
);

  uart_state_e state;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_idx;
  logic [3:0]  nbits_lat;
  logic [7:0]  shreg;

  logic        rx_s;
  logic        sample;
  logic        sample_valid;
  logic        active;
  logic [3:0]  bit_pos;

  // In START the counter is already bit-relative. In DATA/STOP it restarts at
  // the decision tick, so shift it back into bit-relative position for the
  // voter; the decision then lands exactly on the counter wrap.
  assign active  = (state != IDLE);
  assign bit_pos = (state == START) ? tick_cnt : tick_cnt + DECISION_TICK + 4'd1;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .Clk          (Clk),
    .Rst          (Rst),
    .Tick         (Tick),
    .Rx           (Rx),
    .active       (active),
    .bit_pos      (bit_pos),
    .rx_s         (rx_s),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  // Frame FSM: start-bit qualification, data shift-in, stop-bit check and output strobes.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      nbits_lat <= NBITS_MAX;
      shreg     <= '0;
      RxData    <= '0;
      RxDone    <= 1'b0;
      FrameErr  <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here; the strobes default low each Clk so they last one cycle.
      RxDone   <= 1'b0;
      FrameErr <= 1'b0;
      if (Tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state     <= START;
              tick_cnt  <= '0;
              shreg     <= '0;
              nbits_lat <= clamp_nbits(NBits);
            end
          end
          START: begin
            if (sample_valid) begin
              if (sample) begin
                state <= IDLE;
              end else begin
                state    <= DATA;
                tick_cnt <= '0;
                bit_idx  <= '0;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
          DATA: begin
            tick_cnt <= tick_cnt + 4'd1;
            if (sample_valid) begin
              shreg[bit_idx] <= sample;
              bit_idx        <= bit_idx + 3'd1;
              if (bit_idx == 3'(nbits_lat - 4'd1)) state <= STOP;
            end
          end
          STOP: begin
            tick_cnt <= tick_cnt + 4'd1;
            if (sample_valid) begin
              RxData   <= shreg;
              RxDone   <= 1'b1;
              FrameErr <= ~sample;
              // Leave mid stop bit so an immediately following start edge is caught.
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign Busy = (state != IDLE);

endmodule
